// File: rtl/eth_rxstatus_fifo_if.sv
// Status-word handshake between the RX status collector and the
// buffer-descriptor logic that consumes it.
interface eth_rxstatus_fifo_if #(
   parameter int LEN_W = 16
);
   logic             StatVld;
   logic             StatRdy;
   logic [LEN_W+7:0] StatData;
   logic             FifoFull;

   modport master (
      output StatVld,
      output StatData,
      output FifoFull,
      input  StatRdy
   );

   modport slave (
      input  StatVld,
      input  StatData,
      input  FifoFull,
      output StatRdy
   );
endinterface

// File: rtl/eth_rxstatus_fifo.sv
// Receive-side status collector: follows each frame from SOF to EOF,
// gathers sticky error flags, packs {len, flags} at frame end and queues
// the word in a small FIFO that drains over a valid/ready handshake.
// Saturating frame/error/drop statistics are kept alongside.
module eth_rxstatus_fifo #(
   parameter int LEN_W = 16,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic               MRxClk,
   input  logic               Reset,
   input  logic               RxSof,
   input  logic               RxEof,
   input  logic [LEN_W-1:0]   RxByteCnt,
   input  logic               RxCrcError,
   input  logic               MRxErr,
   input  logic               MRxDV,
   input  logic [3:0]         MRxD,
   input  logic               RxDribble,
   input  logic               RxLateColl,
   input  logic               HugEn,
   input  logic [LEN_W-1:0]   MinFL,
   input  logic [LEN_W-1:0]   MaxFL,
   eth_rxstatus_fifo_if.master stat,
   input  logic               CntClr,
   output logic [CNT_W-1:0]   FrameCnt,
   output logic [CNT_W-1:0]   ErrCnt,
   output logic [CNT_W-1:0]   DropCnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int WW = LEN_W + 8;
   localparam logic [AW:0] C_FULL = DEPTH[AW:0];

   typedef enum logic [1:0] {IDLE, FRAME, COMMIT} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_latch;
   logic             w_push_req;

   logic             r_err_seen;
   logic             r_inv_sym;
   logic             r_late_coll;
   logic             w_err_hit;
   logic             w_inv_hit;
   logic             w_crc;
   logic             w_short;
   logic             w_big;

   logic [LEN_W-1:0] r_len_p1;
   logic [6:0]       r_flags_p1;
   logic             r_ovr;

   logic [WW-1:0]    r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;
   logic             w_full;
   logic             w_pop;
   logic             w_push_ok;
   logic             w_drop;

   logic [CNT_W-1:0] r_frame_cnt;
   logic [CNT_W-1:0] r_err_cnt;
   logic [CNT_W-1:0] r_drop_cnt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign w_err_hit = MRxErr & MRxDV;
   assign w_inv_hit = w_err_hit & (MRxD == 4'hE);
   assign w_crc     = RxCrcError & (RxByteCnt != '0);
   assign w_short   = RxByteCnt < MinFL;
   assign w_big     = ~HugEn & (RxByteCnt > MaxFL);

   // Frame tracking state register.
   always_ff @(posedge MRxClk or posedge Reset) begin
      if (Reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next state; a new SOF always wins, so a SOF inside a frame restarts it.
   always_comb begin
      w_state_nxt = r_state;
      w_latch     = 1'b0;
      w_push_req  = 1'b0;
      case (r_state)
         IDLE: begin
            if (RxSof) w_state_nxt = FRAME;
         end
         FRAME: begin
            if (RxSof) begin
               w_state_nxt = FRAME;
            end else if (RxEof) begin
               w_state_nxt = COMMIT;
               w_latch     = 1'b1;
            end
         end
         COMMIT: begin
            w_push_req  = 1'b1;
            w_state_nxt = RxSof ? FRAME : IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Sticky per-frame error flags, cleared whenever a frame (re)starts.
   always_ff @(posedge MRxClk or posedge Reset) begin
      if (Reset) begin
         r_err_seen  <= 1'b0;
         r_inv_sym   <= 1'b0;
         r_late_coll <= 1'b0;
      end else if (RxSof) begin
         r_err_seen  <= 1'b0;
         r_inv_sym   <= 1'b0;
         r_late_coll <= 1'b0;
      end else if (r_state == FRAME) begin
         r_err_seen  <= r_err_seen | w_err_hit;
         r_inv_sym   <= r_inv_sym | w_inv_hit;
         r_late_coll <= r_late_coll | RxLateColl;
      end
   end

   // EOF capture stage: length and flags[6:0], including this cycle's errors.
   always_ff @(posedge MRxClk) begin
      if (w_latch) begin
         r_len_p1   <= RxByteCnt;
         r_flags_p1 <= {r_late_coll | RxLateColl, w_big, w_short, RxDribble,
                        r_inv_sym | w_inv_hit, r_err_seen | w_err_hit, w_crc};
      end
   end

   assign w_full    = (r_count == C_FULL);
   assign w_pop     = (r_count != '0) & stat.StatRdy;
   assign w_push_ok = w_push_req & (~w_full | w_pop);
   assign w_drop    = w_push_req & w_full & ~w_pop;

   // Commit stage: write the packed word, with any pending overrun in bit 7.
   always_ff @(posedge MRxClk) begin
      if (w_push_ok) r_mem[r_wptr] <= {r_len_p1, r_ovr, r_flags_p1};
   end

   // FIFO pointers and occupancy; a full FIFO can push when it also pops.
   always_ff @(posedge MRxClk or posedge Reset) begin
      if (Reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push_ok) r_wptr <= r_wptr + AW'(1);
         if (w_pop)     r_rptr <= r_rptr + AW'(1);
         if (w_push_ok & ~w_pop)      r_count <= r_count + CW'(1);
         else if (~w_push_ok & w_pop) r_count <= r_count - CW'(1);
      end
   end

   // Pending overrun: raised by a dropped frame, consumed by the next push.
   always_ff @(posedge MRxClk or posedge Reset) begin
      if (Reset)          r_ovr <= 1'b0;
      else if (w_push_ok) r_ovr <= 1'b0;
      else if (w_drop)    r_ovr <= 1'b1;
   end

   // Saturating statistics; a clear beats any increment in the same cycle.
   always_ff @(posedge MRxClk or posedge Reset) begin
      if (Reset) begin
         r_frame_cnt <= '0;
         r_err_cnt   <= '0;
         r_drop_cnt  <= '0;
      end else if (CntClr) begin
         r_frame_cnt <= '0;
         r_err_cnt   <= '0;
         r_drop_cnt  <= '0;
      end else begin
         if (w_push_ok) r_frame_cnt <= sat_inc(r_frame_cnt);
         if (w_push_ok & (|r_flags_p1)) r_err_cnt <= sat_inc(r_err_cnt);
         if (w_drop) r_drop_cnt <= sat_inc(r_drop_cnt);
      end
   end

   assign stat.StatVld  = (r_count != '0);
   assign stat.StatData = r_mem[r_rptr];
   assign stat.FifoFull = w_full;
   assign FrameCnt      = r_frame_cnt;
   assign ErrCnt        = r_err_cnt;
   assign DropCnt       = r_drop_cnt;

endmodule

// File: tb/tb_eth_rxstatus_fifo.sv
// Bench for eth_rxstatus_fifo: directed scenarios followed by randomized
// frames, checked against a frame-level queue model.
module tb_eth_rxstatus_fifo;

   localparam int LEN_W = 16;
   localparam int DEPTH = 4;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             MRxClk = 1'b0;
   logic             Reset;
   logic             RxSof, RxEof, RxCrcError, MRxErr, MRxDV, RxDribble;
   logic             RxLateColl, HugEn, CntClr;
   logic [LEN_W-1:0] RxByteCnt, MinFL, MaxFL;
   logic [3:0]       MRxD;
   logic [CNT_W-1:0] FrameCnt, ErrCnt, DropCnt;

   eth_rxstatus_fifo_if #(.LEN_W(LEN_W)) stat_if ();

   eth_rxstatus_fifo #(.LEN_W(LEN_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .MRxClk(MRxClk), .Reset(Reset), .RxSof(RxSof), .RxEof(RxEof),
      .RxByteCnt(RxByteCnt), .RxCrcError(RxCrcError), .MRxErr(MRxErr),
      .MRxDV(MRxDV), .MRxD(MRxD), .RxDribble(RxDribble),
      .RxLateColl(RxLateColl), .HugEn(HugEn), .MinFL(MinFL), .MaxFL(MaxFL),
      .stat(stat_if.master), .CntClr(CntClr), .FrameCnt(FrameCnt),
      .ErrCnt(ErrCnt), .DropCnt(DropCnt)
   );

   always #5 MRxClk = ~MRxClk;

   // reference model state
   logic [LEN_W+7:0] q[$];
   int  m_frame, m_err, m_drop;
   bit  m_ovr;
   bit  a_err, a_inv, a_late;
   int  n_cmp = 0;
   int  n_bad = 0;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "timeout");
   end

   function automatic int sat(input int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge MRxClk);
      #1;
   endtask

   task automatic check_all(input string tag);
      chk({tag, "/vld"},   stat_if.StatVld,  q.size() > 0);
      chk({tag, "/full"},  stat_if.FifoFull, q.size() == DEPTH);
      chk({tag, "/frame"}, FrameCnt, m_frame);
      chk({tag, "/err"},   ErrCnt,   m_err);
      chk({tag, "/drop"},  DropCnt,  m_drop);
      if (q.size() > 0) chk({tag, "/data"}, stat_if.StatData, q[0]);
   endtask

   task automatic clear_phy();
      MRxErr = 1'b0; MRxDV = 1'b0; MRxD = 4'h0; RxLateColl = 1'b0;
   endtask

   task automatic rand_phy();
      MRxErr     = ($urandom_range(0, 7) == 0);
      MRxDV      = ($urandom_range(0, 9) != 0);
      MRxD       = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom_range(0, 15));
      RxLateColl = ($urandom_range(0, 24) == 0);
      a_err  |= MRxErr & MRxDV;
      a_inv  |= MRxErr & MRxDV & (MRxD == 4'hE);
      a_late |= RxLateColl;
   endtask

   task automatic frame_start();
      RxSof = 1'b1;
      a_err = 0; a_inv = 0; a_late = 0;
      tick();
      RxSof = 1'b0;
   endtask

   task automatic body(input int n, input bit rnd);
      for (int i = 0; i < n; i++) begin
         if (rnd) rand_phy();
         tick();
         clear_phy();
      end
   endtask

   task automatic inject_inv();
      MRxErr = 1'b1; MRxDV = 1'b1; MRxD = 4'hE;
      a_err = 1; a_inv = 1;
      tick();
      clear_phy();
   endtask

   task automatic frame_end(input logic [LEN_W-1:0] len, input bit crc, input bit drib,
                            input bit hug, input bit pop, input bit clr,
                            input bit rnd, input bit sof);
      logic [6:0] fl;
      RxEof = 1'b1; RxByteCnt = len; RxCrcError = crc; RxDribble = drib; HugEn = hug;
      if (rnd) rand_phy();
      fl[0] = crc && (len != 0);
      fl[1] = a_err;
      fl[2] = a_inv;
      fl[3] = drib;
      fl[4] = len < MinFL;
      fl[5] = !hug && (len > MaxFL);
      fl[6] = a_late;
      tick();
      RxEof = 1'b0; RxCrcError = 1'b0; RxDribble = 1'b0;
      clear_phy();
      chk("pre_push_vld", stat_if.StatVld, q.size() > 0);
      stat_if.StatRdy = pop;
      CntClr = clr;
      if (sof) begin
         RxSof = 1'b1;
         a_err = 0; a_inv = 0; a_late = 0;
      end
      if (pop && q.size() > 0) chk("commit_pop_head", stat_if.StatData, q[0]);
      tick();
      stat_if.StatRdy = 1'b0; CntClr = 1'b0; RxSof = 1'b0;
      if (pop && q.size() > 0) void'(q.pop_front());
      if (q.size() < DEPTH) begin
         q.push_back({len, m_ovr, fl});
         m_ovr = 0;
         m_frame = sat(m_frame);
         if (|fl) m_err = sat(m_err);
      end else begin
         m_ovr = 1;
         m_drop = sat(m_drop);
      end
      if (clr) begin m_frame = 0; m_err = 0; m_drop = 0; end
      check_all("frame");
   endtask

   task automatic simple_frame(input logic [LEN_W-1:0] len, input bit hug, input bit pop, input bit clr);
      frame_start();
      body(4, 0);
      frame_end(len, 0, 0, hug, pop, clr, 0, 0);
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) begin
         chk("drain_vld", stat_if.StatVld, 1'b1);
         chk("drain_data", stat_if.StatData, q[0]);
         stat_if.StatRdy = 1'b1;
         tick();
         stat_if.StatRdy = 1'b0;
         void'(q.pop_front());
         check_all("drain");
      end
   endtask

   task automatic clr_cnt();
      CntClr = 1'b1;
      tick();
      CntClr = 1'b0;
      m_frame = 0; m_err = 0; m_drop = 0;
      check_all("clr");
   endtask

   initial begin
      bit in_frame;
      int k;
      logic [LEN_W-1:0] len;
      Reset = 1'b1;
      RxSof = 0; RxEof = 0; RxByteCnt = '0; RxCrcError = 0; RxDribble = 0;
      HugEn = 0; CntClr = 0; MinFL = 16'd64; MaxFL = 16'd1518;
      clear_phy();
      stat_if.StatRdy = 1'b0;
      m_frame = 0; m_err = 0; m_drop = 0; m_ovr = 0;

      // reset state
      repeat (3) tick();
      chk("rst_vld", stat_if.StatVld, 1'b0);
      chk("rst_full", stat_if.FifoFull, 1'b0);
      chk("rst_frame", FrameCnt, 0);
      chk("rst_err", ErrCnt, 0);
      chk("rst_drop", DropCnt, 0);
      Reset = 1'b0;
      tick();
      check_all("after_rst");

      // clean 64-byte frame
      simple_frame(16'd64, 0, 0, 0);
      chk("t1_word", stat_if.StatData, 24'h004000);
      chk("t1_frame", FrameCnt, 1);
      chk("t1_err", ErrCnt, 0);
      drain(1);

      // short frame with an invalid symbol
      frame_start();
      body(3, 0);
      inject_inv();
      body(3, 0);
      frame_end(16'd40, 0, 0, 0, 0, 0, 0, 0);
      chk("t2_word", stat_if.StatData, 24'h002816);
      chk("t2_err", ErrCnt, 1);
      drain(1);

      // oversize frame, TooBig check on and off
      simple_frame(16'd1600, 0, 0, 0);
      chk("t3_big", stat_if.StatData, 24'h064020);
      drain(1);
      simple_frame(16'd1600, 1, 0, 0);
      chk("t3_hug", stat_if.StatData, 24'h064000);
      drain(1);

      // EOF while idle is ignored
      RxEof = 1'b1; RxByteCnt = 16'd99;
      tick();
      RxEof = 1'b0;
      repeat (2) tick();
      check_all("eof_idle");

      // overflow: 5 frames into 4 entries, then overrun flag on the next word
      clr_cnt();
      for (int i = 0; i < 5; i++) simple_frame(16'd100, 0, 0, 0);
      chk("t4_full", stat_if.FifoFull, 1'b1);
      chk("t4_drop", DropCnt, 1);
      drain(4);
      simple_frame(16'd64, 0, 0, 0);
      chk("t4_ovr", stat_if.StatData, 24'h004080);
      drain(1);

      // push coinciding with pop while full
      for (int i = 0; i < 4; i++) simple_frame(16'(200 + i), 0, 0, 0);
      simple_frame(16'd300, 0, 1, 0);
      chk("t5_full", stat_if.FifoFull, 1'b1);
      chk("t5_drop", DropCnt, 1);
      drain(4);

      // restart: second SOF discards the first frame's flags
      frame_start();
      inject_inv();
      RxLateColl = 1'b1; a_late = 1;
      tick();
      clear_phy();
      frame_start();
      body(4, 0);
      frame_end(16'd80, 0, 0, 0, 0, 0, 0, 0);
      chk("t6_word", stat_if.StatData, 24'h005000);
      drain(1);
      chk("t6_one_word", stat_if.StatVld, 1'b0);

      // counter saturation and clear-with-push priority
      clr_cnt();
      for (int i = 0; i < 16; i++) begin
         simple_frame(16'd100, 0, 0, 0);
         drain(1);
      end
      chk("t7_sat16", FrameCnt, 4'hF);
      simple_frame(16'd100, 0, 0, 0);
      chk("t7_sat17", FrameCnt, 4'hF);
      drain(1);
      simple_frame(16'd100, 0, 0, 1);
      chk("t7_clr_push", FrameCnt, 0);
      drain(1);

      // randomized frames
      in_frame = 0;
      for (int it = 0; it < 120; it++) begin
         bit chain;
         case ($urandom_range(0, 6))
            0: len = '0;
            1: len = MinFL - 16'd1;
            2: len = MinFL;
            3: len = MaxFL;
            4: len = MaxFL + 16'd1;
            default: len = 16'($urandom_range(0, 2000));
         endcase
         if (!in_frame) frame_start();
         body($urandom_range(1, 6), 1);
         if ($urandom_range(0, 7) == 0) begin
            frame_start();
            body($urandom_range(1, 4), 1);
         end
         chain = ($urandom_range(0, 3) == 0);
         frame_end(len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 15) == 0), 1, chain);
         in_frame = chain;
         if (!in_frame && $urandom_range(0, 2) == 0) begin
            k = $urandom_range(0, q.size());
            drain(k);
         end
      end
      if (in_frame) frame_end(16'd70, 0, 0, 0, 0, 0, 0, 0);

      // asynchronous reset in the middle of a frame
      frame_start();
      body(3, 1);
      Reset = 1'b1;
      #1;
      chk("t9_vld", stat_if.StatVld, 1'b0);
      chk("t9_full", stat_if.FifoFull, 1'b0);
      chk("t9_frame", FrameCnt, 0);
      chk("t9_drop", DropCnt, 0);
      q.delete();
      m_frame = 0; m_err = 0; m_drop = 0; m_ovr = 0;
      tick();
      Reset = 1'b0;
      RxEof = 1'b1; RxByteCnt = 16'd500;
      tick();
      RxEof = 1'b0;
      repeat (2) tick();
      check_all("t9_abort");
      simple_frame(16'd128, 0, 0, 0);
      chk("t9_word", stat_if.StatData, 24'h008000);
      drain(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
